// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter, MSB first, one bit per shift_en strobe
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             frame_valid,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BW-1:0]    bit_cnt, bit_cnt_nx;
    logic [GW-1:0]    gap_cnt, gap_cnt_nx;
    logic             done_nx;
    logic             ready_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        done_nx    = 1'b0;
        ready_raw  = 1'b0;
        case (state)
            S_IDLE: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    shreg_nx   = in_data;
                    bit_cnt_nx = '0;
                    state_nx   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shift_en) begin
                    if (bit_cnt != LAST_BIT) begin
                        shreg_nx   = shreg << 1;
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end else begin
                        done_nx = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_nx   = S_GAP;
                            gap_cnt_nx = '0;
                        end else begin
                            // Streaming: take the next word on the last strobe so no bit time is lost
                            ready_raw = 1'b1;
                            if (in_valid) begin
                                shreg_nx   = in_data;
                                bit_cnt_nx = '0;
                            end else begin
                                state_nx = S_IDLE;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (shift_en) begin
                    if (gap_cnt == LAST_GAP) begin
                        state_nx = S_IDLE;
                    end else begin
                        gap_cnt_nx = gap_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign in_ready    = ready_raw & ~rst;
    assign frame_valid = (state == S_SHIFT);
    assign serial_out  = (state == S_SHIFT) ? shreg[WIDTH-1] : IDLE_LEVEL;

endmodule
